// File: rtl/lcd_timing_if.sv
// Raster timing bundle from the timing generator
// to the colour/pattern display stage.
interface lcd_timing_if;
  logic        out_hs;
  logic        out_vs;
  logic        out_de;
  logic [10:0] x_out;
  logic [10:0] y_out;
  logic        frame_start;
  logic        busy;

  modport master (
    output out_hs, out_vs, out_de,
    output x_out, y_out,
    output frame_start, busy
  );

  modport slave (
    input out_hs, out_vs, out_de,
    input x_out, y_out,
    input frame_start, busy
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: hs/vs/de and x/y
// with a run/idle controller gated on frame ends.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 21,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  lcd_timing_if.master vid
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SY   = 11'(H_SYNC);
  localparam logic [10:0] V_SY   = 11'(V_SYNC);
  localparam logic [10:0] H_DE0  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_DE1  = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_DE0  = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_DE1  = 11'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;

  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        fs_q, fs_d;
  logic        busy_q, busy_d;

  logic        run;

  assign run = (state_q == RUN);

  // FSM and raster counters; stop/start only at the frame end
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    unique case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == V_LAST) begin
            v_cnt_d = '0;
            if (!en) state_d = IDLE;
          end else begin
            v_cnt_d = v_cnt_q + 11'd1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 11'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current counter value
  always_comb begin
    hs_d   = ~HS_POL;
    vs_d   = ~VS_POL;
    de_d   = 1'b0;
    x_d    = '0;
    y_d    = '0;
    fs_d   = 1'b0;
    busy_d = run;
    if (run) begin
      if (h_cnt_q < H_SY) hs_d = HS_POL;
      if (v_cnt_q < V_SY) vs_d = VS_POL;
      de_d = (h_cnt_q >= H_DE0) && (h_cnt_q < H_DE1)
          && (v_cnt_q >= V_DE0) && (v_cnt_q < V_DE1);
      if (de_d) begin
        x_d = h_cnt_q - H_DE0;
        y_d = v_cnt_q - V_DE0;
      end
      fs_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  // Controller state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Registered, mutually aligned outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      de_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      fs_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fs_q   <= fs_d;
      busy_q <= busy_d;
    end
  end

  assign vid.out_hs      = hs_q;
  assign vid.out_vs      = vs_q;
  assign vid.out_de      = de_q;
  assign vid.x_out       = x_q;
  assign vid.y_out       = y_q;
  assign vid.frame_start = fs_q;
  assign vid.busy        = busy_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: a shrunken-timing instance
// and a default 800x480 instance against a pixel-index model.
module tb_lcd_timing_gen;

  localparam int HA  [2] = '{16, 800};
  localparam int HF  [2] = '{4, 40};
  localparam int HSY [2] = '{8, 128};
  localparam int HB  [2] = '{6, 88};
  localparam int VA  [2] = '{10, 480};
  localparam int VF  [2] = '{2, 1};
  localparam int VSY [2] = '{3, 3};
  localparam int VB  [2] = '{2, 21};
  localparam bit HP  [2] = '{1'b1, 1'b0};
  localparam bit VP  [2] = '{1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;

  always #5 clk = ~clk;

  lcd_timing_if s_if ();
  lcd_timing_if d_if ();

  lcd_timing_gen #(
    .H_ACTIVE (HA[0]),
    .H_FP     (HF[0]),
    .H_SYNC   (HSY[0]),
    .H_BP     (HB[0]),
    .V_ACTIVE (VA[0]),
    .V_FP     (VF[0]),
    .V_SYNC   (VSY[0]),
    .V_BP     (VB[0]),
    .HS_POL   (HP[0]),
    .VS_POL   (VP[0])
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .vid   (s_if)
  );

  lcd_timing_gen u_dflt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .vid   (d_if)
  );

  int checks = 0;
  int failures = 0;

  bit run_m [2];
  int p_m   [2];
  logic [26:0] exp_v [2];

  int hs_n [2];
  int vs_n [2];
  int de_n [2];
  int fs_n [2];

  function automatic int frame_len(int d);
    return (HSY[d] + HB[d] + HA[d] + HF[d])
         * (VSY[d] + VB[d] + VA[d] + VF[d]);
  endfunction

  // Expected outputs for linear pixel index p of a frame
  function automatic logic [26:0] ref_out(int d, bit run, int p);
    int ht, h, v, hx, vy;
    logic hs, vs, de, fs;
    logic [10:0] x, y;
    ht = HSY[d] + HB[d] + HA[d] + HF[d];
    h  = p % ht;
    v  = p / ht;
    hx = h - (HSY[d] + HB[d]);
    vy = v - (VSY[d] + VB[d]);
    hs = (run && h < HSY[d]) ? HP[d] : ~HP[d];
    vs = (run && v < VSY[d]) ? VP[d] : ~VP[d];
    de = run && hx >= 0 && hx < HA[d]
      && vy >= 0 && vy < VA[d];
    fs = run && (p == 0);
    x  = de ? 11'(hx) : 11'd0;
    y  = de ? 11'(vy) : 11'd0;
    return {run, fs, hs, vs, de, x, y};
  endfunction

  function automatic logic [26:0] obs(int d);
    if (d == 0)
      return {s_if.busy, s_if.frame_start, s_if.out_hs,
              s_if.out_vs, s_if.out_de, s_if.x_out, s_if.y_out};
    return {d_if.busy, d_if.frame_start, d_if.out_hs,
            d_if.out_vs, d_if.out_de, d_if.x_out, d_if.y_out};
  endfunction

  task automatic check_vec(string tag, logic [26:0] o,
                           logic [26:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_int(string tag, int o, int e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      hs_n[d] = 0;
      vs_n[d] = 0;
      de_n[d] = 0;
      fs_n[d] = 0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      run_m[d] = 1'b0;
      p_m[d] = 0;
    end
  endtask

  // One clock per iteration: predict, clock, compare at negedge
  task automatic step(int n);
    logic [26:0] o;
    repeat (n) begin
      for (int d = 0; d < 2; d++)
        exp_v[d] = ref_out(d, run_m[d], p_m[d]);
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          run_m[d] = 1'b0;
          p_m[d] = 0;
        end else if (run_m[d]) begin
          if (p_m[d] == frame_len(d) - 1) begin
            p_m[d] = 0;
            run_m[d] = en;
          end else begin
            p_m[d]++;
          end
        end else if (en) begin
          run_m[d] = 1'b1;
          p_m[d] = 0;
        end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        o = obs(d);
        check_vec(d == 0 ? "small_cycle" : "dflt_cycle",
                  o, exp_v[d]);
        if (o[24] === HP[d]) hs_n[d]++;
        if (o[23] === VP[d]) vs_n[d]++;
        if (o[22] === 1'b1) de_n[d]++;
        if (o[25] === 1'b1) fs_n[d]++;
      end
    end
  endtask

  initial begin
    bit found;
    model_reset();
    clr();

    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      check_vec("reset_vals", obs(d), ref_out(d, 1'b0, 0));
    @(negedge clk);
    step(3);
    rst_n = 1'b1;
    step(4);
    check_int("idle_busy", s_if.busy, 0);

    // start from idle
    clr();
    en = 1'b1;
    step(2);
    check_int("first_fs_small", s_if.frame_start, 1);
    check_int("first_fs_dflt", d_if.frame_start, 1);
    check_int("first_hs_dflt", d_if.out_hs, 0);
    check_int("first_x_dflt", d_if.x_out, 0);
    check_int("first_busy_dflt", d_if.busy, 1);
    step(1055);
    check_int("line_hs_cnt", hs_n[1], 128);
    check_int("line_vs_cnt", vs_n[1], 1056);
    check_int("line0_de_cnt", de_n[1], 0);
    check_int("small_fs_cnt", fs_n[0], 2);

    // random en activity, mid-frame toggles must be ignored
    repeat (25) begin
      en = 1'($urandom_range(0, 1));
      step($urandom_range(1, 150));
    end

    // one full shrunken frame
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1500 && !found; i++) begin
      clr();
      step(1);
      if (s_if.frame_start === 1'b1) found = 1'b1;
    end
    check_int("wait_fs_small", int'(found), 1);
    step(577);
    check_int("frame_de_cnt", de_n[0], 160);
    check_int("frame_fs_cnt", fs_n[0], 1);
    check_int("frame_vs_cnt", vs_n[0], 3 * 34);
    check_int("frame_hs_cnt", hs_n[0], 8 * 17);
    step(1);
    check_int("fs_period", s_if.frame_start, 1);

    // drop en mid-frame: frame completes, then idle
    clr();
    step(5 * 34);
    en = 1'b0;
    step(577 - 5 * 34);
    check_int("drop_de_cnt", de_n[0], 160);
    check_int("drop_last_busy", s_if.busy, 1);
    step(1);
    clr();
    step(60);
    check_int("idle_fs_cnt", fs_n[0], 0);
    check_int("idle_de_cnt", de_n[0], 0);
    check_int("idle_busy2", s_if.busy, 0);
    check_int("idle_hs", s_if.out_hs, 0);
    check_int("idle_vs", s_if.out_vs, 1);

    // default instance: full active line, then reset at x=400
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60000 && !found; i++) begin
      clr();
      step(1);
      if (d_if.out_de === 1'b1 && d_if.x_out == 11'd0)
        found = 1'b1;
    end
    check_int("wait_de_dflt", int'(found), 1);
    step(1055);
    check_int("dflt_line_de", de_n[1], 800);
    step(401);
    check_int("dflt_x400", d_if.x_out, 400);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++)
      check_vec("async_reset", obs(d), ref_out(d, 1'b0, 0));
    @(negedge clk);
    step(2);
    rst_n = 1'b1;
    step(2);
    check_int("restart_fs_dflt", d_if.frame_start, 1);
    check_int("restart_fs_small", s_if.frame_start, 1);
    check_int("restart_hs_dflt", d_if.out_hs, 0);
    step(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
